// File: rtl/cpu_pkg.sv
// Shared definitions for the 9-bit processor front end and control unit:
// instruction geometry, opcode encodings, sequencer states, opcode screening.
package cpu_pkg;

  localparam int unsigned IW    = 9;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpNan = 3'b010;
  localparam logic [2:0] OpOut = 3'b100;
  localparam logic [2:0] OpLdi = 3'b101;
  localparam logic [2:0] OpRep = 3'b111;

  typedef enum logic [0:0] {
    StIdle,
    StExec
  } seq_state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    logic legal;
    case (op)
      OpAdd, OpSub, OpNan, OpOut, OpLdi, OpRep: legal = 1'b1;
      default:                                  legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Two-entry instruction buffer with 1-bit wrap-around pointers and a
// separately registered fill level.
module instr_fifo
  import cpu_pkg::*;
(
  input  logic          clock,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic [IW-1:0] wdata,
  output logic [IW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [IW-1:0] mem_q [DEPTH];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      // Simultaneous push and pop leaves the level unchanged.
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Front-end sequencer: buffers instructions, screens undefined opcodes, holds
// the IR and drives the 4-step count consumed by the control unit.
module instr_sequencer
  import cpu_pkg::*;
(
  input  logic          clock,
  input  logic          resetn,
  input  logic [IW-1:0] instr_in,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic          run,
  output logic [IW-1:0] ir_out,
  output logic [1:0]    count,
  output logic          busy,
  output logic          done,
  output logic          illegal,
  output logic [LW-1:0] fifo_level
);

  seq_state_e    state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [1:0]    count_q, count_d;
  logic          illegal_q, illegal_d;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [IW-1:0] head;
  logic          head_legal;
  logic          can_load;

  // Held low throughout reset so nothing is accepted while the FIFO is flushed.
  assign instr_ready = resetn && !fifo_full;
  assign fifo_push   = instr_valid && instr_ready;

  instr_fifo u_instr_fifo (
    .clock (clock),
    .resetn(resetn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (instr_in),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign head_legal = is_legal_op(head[IW-1 -: 3]);
  assign can_load   = !fifo_empty && run;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    count_d   = count_q;
    illegal_d = 1'b0;
    fifo_pop  = 1'b0;
    unique case (state_q)
      StIdle: begin
        count_d = 2'b00;
        if (can_load) begin
          fifo_pop = 1'b1;
          if (head_legal) begin
            ir_d    = head;
            state_d = StExec;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StExec: begin
        if (count_q != 2'b11) begin
          count_d = count_q + 2'd1;
        end else begin
          // Retire edge: chain straight into the next legal instruction.
          count_d = 2'b00;
          if (can_load) begin
            fifo_pop = 1'b1;
            if (head_legal) begin
              ir_d = head;
            end else begin
              illegal_d = 1'b1;
              state_d   = StIdle;
            end
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      count_q   <= 2'b00;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  assign ir_out  = ir_q;
  assign count   = count_q;
  assign busy    = (state_q == StExec);
  assign done    = busy && (count_q == 2'b11);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: accepted instructions queue up in
// push order and must emerge either as an IR load (legal) or an illegal pulse.
module tb_instr_sequencer;

  logic       clock = 1'b0;
  logic       resetn;
  logic [8:0] instr_in;
  logic       instr_valid;
  logic       instr_ready;
  logic       run;
  logic [8:0] ir_out;
  logic [1:0] count;
  logic       busy;
  logic       done;
  logic       illegal;
  logic [1:0] fifo_level;

  int         checks = 0;
  int         errors = 0;
  int         ill_cnt = 0;
  logic [8:0] exp_q[$];

  localparam logic [8:0] I_ADD = 9'b000_001_010;
  localparam logic [8:0] I_SUB = 9'b001_010_011;
  localparam logic [8:0] I_LDI = 9'b101_110_001;
  localparam logic [8:0] I_ILL = 9'b011_000_000;
  localparam logic [8:0] I_OUT = 9'b100_011_000;

  instr_sequencer dut (
    .clock      (clock),
    .resetn     (resetn),
    .instr_in   (instr_in),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .run        (run),
    .ir_out     (ir_out),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;

  // Undefined opcodes are 011 and 110; everything else executes.
  function automatic bit legal(input logic [8:0] i);
    return !(i[8:6] == 3'b011 || i[8:6] == 3'b110);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_cycle(input bit v, input logic [8:0] ins, input bit r);
    bit acc;
    @(negedge clock);
    instr_valid = v;
    instr_in    = ins;
    run         = r;
    acc         = v && instr_ready;
    @(posedge clock);
    if (acc) exp_q.push_back(ins);
  endtask

  // Monitor: per-cycle invariants plus scoreboard pops on loads / drops.
  initial begin : monitor
    bit         pb;
    logic [1:0] pc;
    logic [8:0] pir;
    logic [8:0] e;
    pb  = 1'b0;
    pc  = 2'b00;
    pir = '0;
    forever begin
      @(posedge clock);
      #1;
      if (!resetn) begin
        pb = 1'b0;
        pc = 2'b00;
        continue;
      end
      chk("done_decode", done, busy && count == 2'b11);
      chk("ready_vs_level", instr_ready, fifo_level < 2);
      if (!busy) chk("idle_count", count, 0);
      if (pb && pc != 2'b11) begin
        chk("no_truncate", busy, 1);
        chk("count_step", count, pc + 1);
        chk("ir_hold", ir_out, pir);
      end
      if (busy && count == 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load actual=%0h required=none at %0t", ir_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("load_is_legal", legal(e), 1);
          chk("load_ir", ir_out, e);
        end
      end
      if (illegal) begin
        ill_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_illegal actual=1 required=0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("drop_is_illegal", legal(e), 0);
        end
      end
      pb  = busy;
      pc  = count;
      pir = ir_out;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int ill0;
    int n;
    resetn      = 1'b0;
    instr_valid = 1'b1;
    instr_in    = I_ADD;
    run         = 1'b1;

    // Reset with valid held high: nothing may be accepted.
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", instr_ready, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_count", count, 0);
    chk("rst_ir", ir_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_illegal", illegal, 0);
    @(negedge clock);
    instr_valid = 1'b0;
    resetn      = 1'b1;
    #1;
    chk("rel_ready", instr_ready, 1);
    @(posedge clock);
    #1;
    chk("rel_level", fifo_level, 0);
    chk("rel_busy", busy, 0);

    // Single ADD latency.
    drive_cycle(1, I_ADD, 1);
    for (int k = 1; k <= 5; k++) begin
      drive_cycle(0, '0, 1);
      #1;
      if (k <= 4) begin
        chk("lat_busy", busy, 1);
        chk("lat_count", count, k - 1);
        chk("lat_done", done, k == 4);
        chk("lat_ir", ir_out, 9'h00A);
      end else begin
        chk("lat_retire_busy", busy, 0);
        chk("lat_retire_count", count, 0);
        chk("lat_ir_held", ir_out, 9'h00A);
      end
    end

    // Three back-to-back pushes, no bubble between instructions.
    drive_cycle(1, I_ADD, 1);
    drive_cycle(1, I_SUB, 1);
    drive_cycle(1, I_LDI, 1);
    #1;
    chk("b2b_ready_full", instr_ready, 0);
    chk("b2b_level2", fifo_level, 2);
    repeat (3) drive_cycle(0, '0, 1);
    #1;
    chk("b2b_sub_ir", ir_out, I_SUB);
    chk("b2b_sub_busy", busy, 1);
    chk("b2b_sub_count", count, 0);
    chk("b2b_level1", fifo_level, 1);
    chk("b2b_ready_back", instr_ready, 1);
    repeat (4) drive_cycle(0, '0, 1);
    #1;
    chk("b2b_ldi_ir", ir_out, I_LDI);
    chk("b2b_ldi_count", count, 0);
    chk("b2b_level0", fifo_level, 0);
    repeat (4) drive_cycle(0, '0, 1);
    #1;
    chk("b2b_end_busy", busy, 0);

    // Illegal opcode then OUT.
    ill0 = ill_cnt;
    drive_cycle(1, I_ILL, 1);
    drive_cycle(1, I_OUT, 1);
    #1;
    chk("ill_pulse", illegal, 1);
    chk("ill_not_busy", busy, 0);
    drive_cycle(0, '0, 1);
    #1;
    chk("ill_pulse_end", illegal, 0);
    chk("out_ir", ir_out, I_OUT);
    chk("out_busy", busy, 1);
    repeat (4) drive_cycle(0, '0, 1);
    #1;
    chk("ill_count", ill_cnt - ill0, 1);
    chk("out_end_busy", busy, 0);

    // run dropped mid-instruction with an entry waiting.
    drive_cycle(1, I_ADD, 1);
    drive_cycle(1, I_SUB, 1);
    repeat (6) drive_cycle(0, '0, 0);
    #1;
    chk("hold_busy", busy, 0);
    chk("hold_level", fifo_level, 1);
    chk("hold_ir", ir_out, I_ADD);
    drive_cycle(0, '0, 1);
    #1;
    chk("resume_ir", ir_out, I_SUB);
    chk("resume_busy", busy, 1);
    chk("resume_level", fifo_level, 0);
    repeat (4) drive_cycle(0, '0, 1);

    // Asynchronous reset at count 10 with two entries buffered.
    drive_cycle(1, I_ADD, 1);
    drive_cycle(1, I_SUB, 1);
    drive_cycle(1, I_LDI, 1);
    drive_cycle(0, '0, 1);
    #1;
    chk("pre_rst_count", count, 2);
    chk("pre_rst_level", fifo_level, 2);
    #1;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_count", count, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ir", ir_out, 0);
    chk("arst_ready", instr_ready, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    repeat (6) drive_cycle(0, '0, 1);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_level", fifo_level, 0);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      logic [8:0] ins;
      ins = {3'($urandom_range(0, 7)), 6'($urandom)};
      drive_cycle(1'($urandom_range(0, 1)), ins, $urandom_range(0, 3) != 0);
    end
    n = 0;
    drive_cycle(0, '0, 1);
    #1;
    while ((exp_q.size() != 0 || busy) && n < 60) begin
      drive_cycle(0, '0, 1);
      #1;
      n++;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_busy", busy, 0);
    chk("drain_level", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Front-end stage of the 9-bit processor, directly upstream of the control unit. Buffers incoming instructions in a 2-entry FIFO, holds the current instruction register (IR), and generates the 2-bit step count (00→01→10→11) the control unit consumes as `in`/`count`. Screens out undefined opcodes before they reach the control unit.

## Interface
- DEPTH, 2, FIFO entries (fixed at 2; `fifo_level` width depends on it)
- IW, 9, instruction width: opcode [8:6], reg A [5:3], reg B [2:0]
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- instr_in  in  9  instruction from source (switches/memory)
- instr_valid  in  1  instr_in is valid this cycle
- instr_ready  out  1  FIFO can accept (= level < DEPTH)
- run  in  1  permit loading a new instruction into IR
- ir_out  out  9  current instruction → control unit `in`
- count  out  2  step counter → control unit `count`
- busy  out  1  instruction executing (state EXEC)
- done  out  1  high while count==11 in EXEC (last step)
- illegal  out  1  one-cycle pulse when an undefined opcode is dropped
- fifo_level  out  2  entries held, 0..2

## Operation
- Push: on `instr_valid && instr_ready`, write instr_in at tail. No push when full.
- States: IDLE, EXEC.
- IDLE: if level>0 and run=1, pop head. Legal opcode → IR<=head, count<=00, go EXEC. Illegal opcode (011, 110) → discard, `illegal`=1 next cycle, IR and count unchanged, stay IDLE.
- EXEC: count increments every cycle. At count==11 (retire edge): if level>0 and run=1 and head legal → pop, load IR, count<=00, stay EXEC (no bubble). If head illegal → pop, discard, pulse `illegal`, go IDLE. Otherwise go IDLE, count<=00.
- IR holds its last value in IDLE; count rests at 00.
- `run` is sampled only at load decisions; deasserting run mid-instruction never truncates it.
- Simultaneous push and pop: both happen, level unchanged. Pop when full frees a slot; `instr_ready` rises the following cycle (registered level, no combinational pass-through).
- Legal opcodes: ADD 000, SUB 001, NAN 010, OUT 100, LDI 101, REP 111.

## Timing
- Reset (async assert, sync-safe deassert): FIFO empty, level 0, IR 0, count 00, state IDLE, busy/done/illegal 0, instr_ready 0 while resetn low, 1 after.
- Reset mid-instruction: instruction aborted, FIFO flushed, all outputs to reset values immediately.
- Latency (empty, IDLE, run=1): push at edge t → IR valid, count=00 after t+1; 01 at t+2; 10 at t+3; 11 (done=1) at t+4; retire at t+5.
- Throughput: one legal instruction per 4 cycles when FIFO non-empty.
- `done`, `busy` are decoded from registered state/count; `illegal` is registered.
- FIFO pointers: 1-bit wrap-around; level tracked separately.

## Structure
- Package `cpu_pkg`: opcode localparams, IW, DEPTH, state enum, `is_legal_op` function; shared with control unit.
- Sub-module `instr_fifo` (DEPTH×IW, push/pop/full/empty/level); sequencer FSM + IR + counter in top.

## Test plan
- Reset: hold resetn=0 with instr_valid=1 → ready=0, level 0, count 00, IR 0; release → ready=1, nothing accepted during reset.
- Single ADD 9'b000_001_010 pushed into empty/IDLE → IR=0x00A after t+1, count 00,01,10,11 at t+1..t+4, done only at t+4, busy drops at t+5.
- Three back-to-back pushes (ADD, SUB, LDI) → ready low after 2 buffered with one executing, counts run 00..11 three times with no 00 bubble, level 2→1→0.
- Illegal 9'b011_000_000 followed by OUT 9'b100_011_000 → one `illegal` pulse, IR never shows 011, OUT executes normally.
- run=0 during EXEC with FIFO non-empty → current instruction finishes, IDLE with level unchanged; run=1 → next loads one cycle later.
- resetn pulsed low at count=10 with level 2 → count 00, level 0, busy 0 asynchronously; no instruction resumes.
